mmio_periph: RTL and testbench
==============================

MMIO_PERIPH -- requirements
Module: mmio_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning base of 32-byte register window (aligned to 32 bytes).
REQ-002 SHALL have parameter SW_WIDTH, default 16, meaning switch/LED width (1..16).
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port read  input  4  load request; bit3 = enable, [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 SHALL have port write  input  3  store request; bit2 = enable, [1:0] = funct3 (00 SB, 01 SH, 10 SW).
REQ-007 SHALL have port address  input  32  byte address of the request.
REQ-008 SHALL have port writedata  input  32  store data, right-aligned.
REQ-009 SHALL have port readdata  output  32  load result, extended per funct3.
REQ-010 SHALL have port busywait  output  1  stall request to CPU.
REQ-011 SHALL have port switches  input  SW_WIDTH  asynchronous board switches.
REQ-012 SHALL have port leds  output  SW_WIDTH  LED register contents.
REQ-013 SHALL have port irq  output  1  timer match flag (STATUS bit0).

Function
REQ-014 SHALL decode "selected" as (read[3] or write[2]) and address[31:5] == BASE_ADDR[31:5]; an unselected request gets no response: busywait 0, no state change.
REQ-015 SHALL map word offsets address[4:2]: 0 LED (RW), 1 SWITCH (RO), 2 CYCLE (RO), 3 TIMER_CMP (RW), 4 STATUS (bit0 RW1C); offsets 5-7 read 0, writes ignored.
REQ-016 SHALL use FSM IDLE -> BUSY -> DONE -> IDLE; IDLE->BUSY on selected request, BUSY->DONE unconditionally, DONE->IDLE unconditionally.
REQ-017 SHALL drive busywait = selected request in IDLE (combinational) or state BUSY; busywait 0 in DONE.
REQ-018 SHALL latch address, read, write, writedata on IDLE->BUSY; register access uses latched values only.
REQ-019 SHALL perform the register write on the BUSY->DONE edge; readdata valid throughout DONE, 0 in all other states.
REQ-020 SHALL ignore any request present in DONE (CPU releases it on that edge); back-to-back requests therefore cost 3 cycles each.
REQ-021 SHALL if read and write enables are both set, treat the request as a write.
REQ-022 SHALL implement byte lanes: SB writes byte address[1:0], SH writes halfword address[1], SW writes whole word; address[1:0] ignored for SW/LW, address[0] ignored for SH/LH.
REQ-023 SHALL sign-extend LB/LH and zero-extend LBU/LHU from the selected lane; unsupported funct3 codes return 0 and store nothing.
REQ-024 SHALL keep LED as SW_WIDTH bits; bits above SW_WIDTH read 0, written bits discarded.
REQ-025 SHALL synchronise switches through two flops; SWITCH reads the second-stage value, upper bits 0.
REQ-026 SHALL increment 32-bit CYCLE every cycle, wrapping 32'hFFFF_FFFF -> 0; not writable.
REQ-027 SHALL set STATUS bit0 in the cycle after CYCLE == TIMER_CMP; sticky until cleared by a write with writedata[0] = 1 to offset 4.
REQ-028 SHALL give set priority when match and clear occur on the same edge (flag stays 1).
REQ-029 SHALL drive irq = STATUS bit0 and leds = LED register directly from flops.

Reset
REQ-030 SHALL on reset low, immediately: state IDLE, LED 0, TIMER_CMP 32'hFFFF_FFFF, CYCLE 0, STATUS 0, sync flops 0, latched request 0; hence readdata 0, leds 0, irq 0, busywait follows REQ-017.
REQ-031 SHALL abort an in-flight access on reset with no register write, resuming in IDLE after release.

Verification
REQ-032 SHALL verify SW 32'h0000_A5A5 to BASE_ADDR+0 -> busywait 1 for two cycles, leds = 16'hA5A5 after DONE edge; LW reads back 32'h0000_A5A5.
REQ-033 SHALL verify SB 8'hFF to BASE_ADDR+1 after LED = 0 -> LED 16'hFF00; LB from +1 returns 32'hFFFF_FFFF, LBU returns 32'h0000_00FF.
REQ-034 SHALL verify TIMER_CMP = 20 after reset -> irq rises the cycle after CYCLE == 20; write 1 to STATUS clears it; clear coinciding with a second match keeps irq 1.
REQ-035 SHALL verify LW at BASE_ADDR+32 (outside window) -> busywait stays 0, readdata 0, no register changes.
REQ-036 SHALL verify reset asserted in BUSY of SW to LED -> leds 0 immediately, LED unchanged after release, next access completes normally.
REQ-037 SHALL verify switches = 16'h1234 stable -> LW at +4 returns 32'h0000_1234; CYCLE read back-to-back differs by 3.

Source files
------------

// File: rtl/mmio_periph.sv
// mmio_periph: memory-mapped LED / switch / cycle-counter / timer peripheral.
// A 32-byte register window at BASE_ADDR. Each selected access takes the
// IDLE -> BUSY -> DONE handshake: the request is captured on entry to BUSY,
// the register write and load capture happen on the BUSY -> DONE edge, and
// readdata is presented from a flop for the whole DONE cycle.
module mmio_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int unsigned SW_WIDTH  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          read,
   input  logic [2:0]          write,
   input  logic [31:0]         address,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic                busywait,
   input  logic [SW_WIDTH-1:0] switches,
   output logic [SW_WIDTH-1:0] leds,
   output logic                irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Word offsets inside the window (address[4:2]).
   localparam logic [2:0] OFF_LED    = 3'd0;
   localparam logic [2:0] OFF_SWITCH = 3'd1;
   localparam logic [2:0] OFF_CYCLE  = 3'd2;
   localparam logic [2:0] OFF_TCMP   = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;

   state_t              state_q, state_d;

   // Captured request; only the in-window offset bits are kept.
   logic [4:0]          addr_q;
   logic [3:0]          rd_q;
   logic [2:0]          wr_q;
   logic [31:0]         wdata_q;

   // Architectural registers.
   logic [SW_WIDTH-1:0] led_q, led_d;
   logic [31:0]         tcmp_q, tcmp_d;
   logic [31:0]         cycle_q;
   logic                status_q, status_d;
   logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
   logic [31:0]         rdata_q, rdata_d;

   // Decode / datapath intermediates.
   logic                selected;
   logic                capture_en;
   logic                access_en;
   logic [2:0]          offset;
   logic [31:0]         reg_word;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [31:0]         load_val;
   logic                store_ok;
   logic [31:0]         wmask;
   logic [31:0]         wdata_sh;
   logic [31:0]         merged;
   logic                timer_match;
   logic                status_clr;

   assign selected = (read[3] | write[2]) && (address[31:5] == BASE_ADDR[31:5]);
   assign offset   = addr_q[4:2];

   // State register; reset aborts any access in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Handshake sequencing; busywait is combinational from the request in IDLE.
   always_comb begin
      state_d    = state_q;
      busywait   = 1'b0;
      capture_en = 1'b0;
      access_en  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (selected) begin
               busywait   = 1'b1;
               capture_en = 1'b1;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            busywait  = 1'b1;
            access_en = 1'b1;
            state_d   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Request capture on IDLE -> BUSY.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         wdata_q <= '0;
      end else if (capture_en) begin
         addr_q  <= address[4:0];
         rd_q    <= read;
         wr_q    <= write;
         wdata_q <= writedata;
      end
   end

   // Register read mux over the window; unmapped offsets read as zero.
   always_comb begin
      reg_word = '0;
      case (offset)
         OFF_LED:    reg_word = 32'(led_q);
         OFF_SWITCH: reg_word = 32'(sw_sync_q);
         OFF_CYCLE:  reg_word = cycle_q;
         OFF_TCMP:   reg_word = tcmp_q;
         OFF_STATUS: reg_word = {31'b0, status_q};
         default:    reg_word = '0;
      endcase
   end

   // Load lane selection and sign/zero extension.
   always_comb begin
      lane_b = '0;
      case (addr_q[1:0])
         2'd0:    lane_b = reg_word[7:0];
         2'd1:    lane_b = reg_word[15:8];
         2'd2:    lane_b = reg_word[23:16];
         default: lane_b = reg_word[31:24];
      endcase
      lane_h = addr_q[1] ? reg_word[31:16] : reg_word[15:0];
      case (rd_q[2:0])
         3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
         3'b010:  load_val = reg_word;
         3'b100:  load_val = {24'b0, lane_b};
         3'b101:  load_val = {16'b0, lane_h};
         default: load_val = '0;
      endcase
   end

   // Store lane mask and right-aligned data moved onto the target lane.
   always_comb begin
      wmask    = '0;
      wdata_sh = '0;
      case (wr_q[1:0])
         2'b00: begin
            wmask    = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            wdata_sh = {24'b0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
         end
         2'b01: begin
            wmask    = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wdata_sh = addr_q[1] ? {wdata_q[15:0], 16'b0} : {16'b0, wdata_q[15:0]};
         end
         2'b10: begin
            wmask    = 32'hFFFF_FFFF;
            wdata_sh = wdata_q;
         end
         default: begin
            wmask    = '0;
            wdata_sh = '0;
         end
      endcase
      merged = (reg_word & ~wmask) | (wdata_sh & wmask);
   end

   // A write enable wins over a simultaneous read enable.
   assign store_ok    = access_en && wr_q[2] && (wr_q[1:0] != 2'b11);
   assign timer_match = (cycle_q == tcmp_q);
   assign status_clr  = store_ok && (offset == OFF_STATUS) && wdata_q[0];

   // Next values of writable registers and the load capture.
   always_comb begin
      led_d    = led_q;
      tcmp_d   = tcmp_q;
      rdata_d  = '0;
      if (store_ok && (offset == OFF_LED)) begin
         led_d = merged[SW_WIDTH-1:0];
      end
      if (store_ok && (offset == OFF_TCMP)) begin
         tcmp_d = merged;
      end
      if (access_en && !wr_q[2] && rd_q[3]) begin
         rdata_d = load_val;
      end
      // Match sets and wins over a coincident clear.
      status_d = timer_match | (status_q & ~status_clr);
   end

   // Architectural registers and the registered load result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         led_q    <= '0;
         tcmp_q   <= '1;
         status_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         led_q    <= led_d;
         tcmp_q   <= tcmp_d;
         status_q <= status_d;
         rdata_q  <= rdata_d;
      end
   end

   // Free-running cycle counter, wraps naturally at 32 bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   // Two-flop synchroniser for the asynchronous board switches.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= switches;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign readdata = rdata_q;
   assign leds     = led_q;
   assign irq      = status_q;

endmodule

// File: tb/tb_mmio_periph.sv
// tb_mmio_periph: randomized and directed stimulus for mmio_periph, checked
// every cycle against a transaction-level model of the register window.
module tb_mmio_periph;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int unsigned SWW  = 16;

   logic            clock = 1'b0;
   logic            reset;
   logic [3:0]      read;
   logic [2:0]      write;
   logic [31:0]     address;
   logic [31:0]     writedata;
   logic [31:0]     readdata;
   logic            busywait;
   logic [SWW-1:0]  switches;
   logic [SWW-1:0]  leds;
   logic            irq;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_on      = 1'b0;

   mmio_periph #(.BASE_ADDR(BASE), .SW_WIDTH(SWW)) dut (
      .clock(clock), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata),
      .busywait(busywait), .switches(switches), .leds(leds), .irq(irq)
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A selected request occupies three cycles; its effect lands at the end
   // of the second, and its load result is visible during the third.
   int unsigned     m_left;
   logic [15:0]     m_led;
   logic [31:0]     m_cmp, m_cyc, m_rdata;
   logic            m_status;
   logic [15:0]     m_sw1, m_sw2;
   logic [4:0]      q_addr;
   logic [3:0]      q_rd;
   logic [2:0]      q_wr;
   logic [31:0]     q_wd;
   logic [31:0]     m_old, m_nv, m_mask;
   logic            m_match, m_clr;
   int              m_sh;

   function automatic bit in_win(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a);
      return (r[3] || w[2]) && (a[31:5] == BASE[31:5]);
   endfunction

   function automatic logic [31:0] m_regval(input logic [2:0] off);
      case (off)
         3'd0:    return 32'(m_led);
         3'd1:    return 32'(m_sw2);
         3'd2:    return m_cyc;
         3'd3:    return m_cmp;
         3'd4:    return {31'b0, m_status};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
      logic [31:0] b, h;
      b = (w >> (8 * int'(a))) & 32'hFF;
      h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      case (f3)
         3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
         3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
         3'b010:  return w;
         3'b100:  return b;
         3'b101:  return h;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_left = 0; m_led = '0; m_cmp = '1; m_cyc = '0; m_status = 1'b0;
         m_sw1 = '0; m_sw2 = '0; m_rdata = '0;
      end else begin
         m_match = (m_cyc == m_cmp);
         m_clr   = 1'b0;
         if (m_left == 0) begin
            m_rdata = '0;
            if (in_win(read, write, address)) begin
               q_addr = address[4:0]; q_rd = read; q_wr = write; q_wd = writedata;
               m_left = 2;
            end
         end else if (m_left == 2) begin
            m_old   = m_regval(q_addr[4:2]);
            m_rdata = '0;
            if (q_wr[2]) begin
               if (q_wr[1:0] != 2'b11) begin
                  m_sh   = (q_wr[1:0] == 2'b00) ? 8 * int'(q_addr[1:0]) :
                           (q_wr[1:0] == 2'b01) ? 16 * int'(q_addr[1]) : 0;
                  m_mask = ((q_wr[1:0] == 2'b00) ? 32'hFF :
                            (q_wr[1:0] == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF) << m_sh;
                  m_nv   = (m_old & ~m_mask) | ((q_wd << m_sh) & m_mask);
                  if (q_addr[4:2] == 3'd0) m_led = m_nv[15:0];
                  if (q_addr[4:2] == 3'd3) m_cmp = m_nv;
                  if (q_addr[4:2] == 3'd4 && q_wd[0]) m_clr = 1'b1;
               end
            end else begin
               m_rdata = m_load(m_old, q_rd[2:0], q_addr[1:0]);
            end
            m_left = 1;
         end else begin
            m_rdata = '0;
            m_left  = 0;
         end
         m_status = (m_status && !m_clr) || m_match;
         m_cyc    = m_cyc + 32'd1;
         m_sw2    = m_sw1;
         m_sw1    = switches;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      if (chk_on) begin
         chk("busywait", {31'b0, busywait},
             {31'b0, ((m_left == 0) && in_win(read, write, address)) || (m_left == 2)});
         chk("readdata", readdata, m_rdata);
         chk("leds", 32'(leds), 32'(m_led));
         chk("irq", {31'b0, irq}, {31'b0, m_status});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Present a request right after a rising edge and hold it until DONE
   // (or for one cycle when nobody answers), then release it on the next edge.
   task automatic xact(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdata);
      int n;
      read = rd; write = wr; address = a; writedata = wd;
      rdata = '0;
      for (n = 0; n < 6; n++) begin
         @(negedge clock);
         if (!busywait) begin
            rdata = readdata;
            break;
         end
      end
      if (n == 6) chk("xact_timeout", 32'(n), 32'd3);
      step();
      read = '0; write = '0;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b0;
      read = '0; write = '0;
      repeat (cycles) @(negedge clock);
      reset = 1'b1;
      step();
   endtask

   logic [31:0] rd_v, r1, r2;
   logic [3:0]  t_rd;
   logic [2:0]  t_wr;
   logic [31:0] t_a, t_wd;
   int unsigned kind;

   initial begin
      reset = 1'b0; read = '0; write = '0; address = '0; writedata = '0; switches = '0;
      @(posedge clock);
      chk_on = 1'b1;
      @(negedge clock);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_leds", 32'(leds), 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_busywait", {31'b0, busywait}, 32'h0);
      reset = 1'b1;
      step();

      // SW / LW on LED
      xact(4'h0, 3'b110, BASE + 0, 32'h0000_A5A5, rd_v);
      chk("led_after_sw", 32'(leds), 32'h0000_A5A5);
      xact(4'b1010, 3'b000, BASE + 0, 32'h0, rd_v);
      chk("lw_led", rd_v, 32'h0000_A5A5);

      // SB to byte 1, signed and unsigned byte loads
      xact(4'h0, 3'b110, BASE + 0, 32'h0, rd_v);
      xact(4'h0, 3'b100, BASE + 1, 32'h0000_00FF, rd_v);
      chk("led_after_sb", 32'(leds), 32'h0000_FF00);
      xact(4'b1000, 3'b000, BASE + 1, 32'h0, rd_v);
      chk("lb_sext", rd_v, 32'hFFFF_FFFF);
      xact(4'b1100, 3'b000, BASE + 1, 32'h0, rd_v);
      chk("lbu_zext", rd_v, 32'h0000_00FF);

      // Outside the window: no response, no change
      xact(4'b1010, 3'b000, BASE + 32, 32'h0, rd_v);
      chk("outside_rdata", rd_v, 32'h0);
      chk("outside_leds", 32'(leds), 32'h0000_FF00);

      // Switches through the synchroniser; back-to-back CYCLE reads
      switches = 16'h1234;
      repeat (3) step();
      xact(4'b1010, 3'b000, BASE + 4, 32'h0, rd_v);
      chk("lw_switch", rd_v, 32'h0000_1234);
      xact(4'b1010, 3'b000, BASE + 8, 32'h0, r1);
      xact(4'b1010, 3'b000, BASE + 8, 32'h0, r2);
      chk("cycle_delta", r2 - r1, 32'd3);

      // Timer match, W1C clear, and clear coinciding with a match
      do_reset(2);
      xact(4'h0, 3'b110, BASE + 12, 32'd20, rd_v);
      for (int i = 0; i < 60 && !irq; i++) @(negedge clock);
      chk("irq_rose", {31'b0, irq}, 32'h1);
      chk("irq_rise_cycle", m_cyc, 32'd21);
      step();
      xact(4'h0, 3'b110, BASE + 16, 32'h1, rd_v);
      chk("irq_cleared", {31'b0, irq}, 32'h0);
      xact(4'b1010, 3'b000, BASE + 8, 32'h0, r1);
      xact(4'h0, 3'b110, BASE + 12, r1 + 32'd6, rd_v);
      xact(4'h0, 3'b110, BASE + 16, 32'h1, rd_v);
      chk("irq_set_priority", {31'b0, irq}, 32'h1);

      // Reset during BUSY of a store to LED
      xact(4'h0, 3'b110, BASE + 0, 32'h0000_00C3, rd_v);
      read = '0; write = 3'b110; address = BASE; writedata = 32'h0000_BEEF;
      step();
      reset = 1'b0; write = '0;
      #1;
      chk("leds_in_reset", 32'(leds), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) step();
      chk("leds_after_abort", 32'(leds), 32'h0);
      xact(4'h0, 3'b110, BASE + 0, 32'h0000_1111, rd_v);
      chk("leds_after_resume", 32'(leds), 32'h0000_1111);

      // Randomized traffic
      for (int t = 0; t < 400; t++) begin
         kind = $urandom_range(0, 15);
         t_a  = BASE | ($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
         t_wd = $urandom;
         case ($urandom_range(0, 7))
            0:       t_rd = {1'b1, 3'b000};
            1:       t_rd = {1'b1, 3'b001};
            2:       t_rd = {1'b1, 3'b100};
            3:       t_rd = {1'b1, 3'b101};
            4:       t_rd = {1'b1, 3'($urandom_range(0, 7))};
            default: t_rd = {1'b1, 3'b010};
         endcase
         t_wr = {1'b1, (kind == 1) ? 2'b11 : 2'($urandom_range(0, 2))};
         if (kind < 6) t_rd[3] = 1'b0;
         else if (kind < 12) t_wr[2] = 1'b0;
         if (kind == 15) begin
            t_a = $urandom;
            if (t_a[31:5] == BASE[31:5]) t_a[20] = ~t_a[20];
         end
         if (t_a[4:2] == 3'd3) t_wd = m_cyc + 32'($urandom_range(3, 12));
         if ($urandom_range(0, 3) == 0) switches = 16'($urandom);
         xact(t_rd, t_wr, t_a, t_wd, rd_v);
         repeat ($urandom_range(0, 2)) step();
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
